txeread: RTL and testbench
==========================

# txeread

Packet-memory reader for the Ethernet transmit path. On a start command it reads a packet of a given byte length from a 32-bit-wide transmit buffer and emits it as a byte stream with valid/ready flow control to the downstream nibble/serializer filters. Memory word layout matches the receive path: the first byte of each word is in bits [31:24], the last in [7:0]. It is the transmit-side counterpart of the receive write filter and shares its `AW` addressing convention.

## Interface

- `AW`, 12, word address width of the transmit buffer; byte lengths are `AW+2` bits.
- `i_clk`  in  1  system clock.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_cmd`  in  1  start pulse; sampled only while `o_busy` is low.
- `i_len`  in  AW+2  packet length in bytes, sampled with `i_cmd`.
- `o_busy`  out  1  packet in progress.
- `o_rd`  out  1  read strobe to buffer memory.
- `o_raddr`  out  AW  word read address.
- `i_rdata`  in  32  read data; during cycle k+1 holds mem[`o_raddr` of cycle k] when `o_rd` was high in cycle k.
- `o_v`  out  1  output byte valid.
- `o_d`  out  8  output byte.
- `o_last`  out  1  qualifies final byte of packet (valid with `o_v`).
- `i_ready`  in  1  downstream accepts `o_d` when `o_v && i_ready`.

## Operation

- Reset values: `o_busy`=0, `o_rd`=0, `o_raddr`=0, `o_v`=0, `o_d`=0, `o_last`=0; internal counters and buffers cleared. Reset mid-packet abandons the packet immediately; no further reads or bytes.
- States: IDLE, RUN, DRAIN.
  - IDLE: `i_cmd` with effective length N>0 -> RUN; N=0 -> stay IDLE, nothing issued.
  - RUN: issues reads for words 0..ceil(L/4)-1 in ascending order, each exactly once, where L = `i_len`; enters DRAIN after last read issued.
  - DRAIN: emits remaining bytes; after handshake of the byte with `o_last` -> IDLE.
- Byte order within a word: [31:24], [23:16], [15:8], [7:0]. Bytes past L in the final word are discarded.
- Internal buffer: current shift word plus one prefetch word. A read is issued only when a slot is guaranteed free on data return, so no read data is ever lost or re-read.
- Handshake: while `o_v && !i_ready`, `o_v`, `o_d`, `o_last` hold stable. `o_v` never drops without a handshake until packet end.
- `i_cmd` while `o_busy` is ignored. `i_len` ignored except with `i_cmd`.
- Byte counter is AW+2 bits; max length 2^(AW+2)-1, no wrap within a packet.

## Timing

- Cycle 0 `i_cmd` sampled; cycle 1 `o_busy`=1, `o_rd`=1, `o_raddr`=0; cycle 2 word 0 captured; cycle 3 `o_v`=1 with byte 0.
- With `i_ready` held high, one byte per clock, no bubbles, from cycle 3 through byte N-1 (at cycle N+2).
- `o_busy` falls the cycle after the final handshake; a new `i_cmd` is accepted that same cycle.
- `o_rd` is a registered single-cycle strobe per word.

## Configuration

- `TXEREAD_PAD_EN`: defined -> effective length N = max(L, 60); bytes L..59 are emitted as 8'h00 without memory reads (reads still cover ceil(L/4) words only); L=0 yields 60 zero bytes, no reads. Undefined -> N = L; no padding, L=0 ignored.

## Test plan

- L=6, `i_ready`=1: reads addr 0 then 1; mem[0]=32'h11223344, mem[1]=32'h5566xxxx -> bytes 11,22,33,44,55,66 cycles 3-8, `o_last` on 66, `o_busy` low cycle 9.
- L=8, `i_ready` toggling 1/0: same bytes, each held stable while not ready, no duplicates or drops, exactly 2 reads.
- L=0 without macro: no `o_busy`, no `o_rd`, no `o_v`.
- L=10 with `TXEREAD_PAD_EN`: 3 reads, 60 bytes, bytes 10-59 = 00, `o_last` on byte 59.
- `i_cmd` with L=20 while busy on L=5 packet: ignored; only 5 bytes emitted.
- `i_reset` at byte 3 of L=16 packet: next cycle all outputs 0; no further reads or bytes; following `i_cmd` L=4 starts cleanly from addr 0.

Source files
------------

// File: rtl/txeread_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | txeread_if : command, buffer-memory and byte-stream bundle for txeread     |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
interface txeread_if #(
  parameter int AW = 12
);
  logic          i_cmd;
  logic [AW+1:0] i_len;
  logic          o_busy;
  logic          o_rd;
  logic [AW-1:0] o_raddr;
  logic [31:0]   i_rdata;
  logic          o_v;
  logic [7:0]    o_d;
  logic          o_last;
  logic          i_ready;

  modport master (
    input  i_cmd, i_len, i_rdata, i_ready,
    output o_busy, o_rd, o_raddr, o_v, o_d, o_last
  );

  modport slave (
    output i_cmd, i_len, i_rdata, i_ready,
    input  o_busy, o_rd, o_raddr, o_v, o_d, o_last
  );
endinterface
`default_nettype wire

// File: rtl/txeread.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | txeread : transmit-buffer reader, 32-bit words out as a valid/ready bytes  |
// | Option  : TXEREAD_PAD_EN pads short packets with zero bytes to 60 bytes    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module txeread #(
  parameter int AW = 12
) (
  input  logic      i_clk,
  input  logic      i_reset,
  txeread_if.master bus
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_busy;
  logic          r_rd;
  logic [AW-1:0] r_raddr;
  logic          r_v;
  logic [7:0]    r_d;
  logic          r_last;
  logic [AW+1:0] r_len;
  logic [AW+1:0] r_n;
  logic [AW+1:0] r_lcnt;
  logic [AW:0]   r_nwords;
  logic [AW:0]   r_wcnt;
  logic [31:0]   r_sh;
  logic [2:0]    r_shn;
  logic [31:0]   r_pf;
  logic          r_pfv;
  logic          r_dv;

  logic [AW+1:0] w_n;
  logic [AW:0]   w_nwords;
  logic          w_sh_has;
  logic          w_pad;
  logic          w_take;
  logic          w_src;
  logic [7:0]    w_byte;
  logic [2:0]    w_occ;
  logic          w_fin;

  always_comb begin
`ifdef TXEREAD_PAD_EN
    w_n = (bus.i_len < (AW+2)'(60)) ? (AW+2)'(60) : bus.i_len;
`else
    w_n = bus.i_len;
`endif
    w_nwords = {1'b0, bus.i_len[AW+1:2]} + {{AW{1'b0}}, |bus.i_len[1:0]};
    w_sh_has = (r_shn != 3'd0);
    w_pad    = (r_lcnt >= r_len);
    w_take   = r_busy && (!r_v || bus.i_ready) && (r_lcnt != r_n) &&
               (w_pad || w_sh_has || r_pfv || r_dv);
    w_src    = w_take && !w_pad;
    // Oldest byte first: shift word, then prefetch word, then data returning now
    if (w_pad)         w_byte = 8'h00;
    else if (w_sh_has) w_byte = r_sh[31:24];
    else if (r_pfv)    w_byte = r_pf[31:24];
    else               w_byte = bus.i_rdata[31:24];
    // Words held or in flight; a new read is allowed only when this is below 2,
    // which guarantees a free slot when its data returns two cycles later
    w_occ = 3'(w_sh_has) + 3'(r_pfv) + 3'(r_dv) + 3'(r_rd);
    w_fin = r_v && bus.i_ready && r_last;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_rd     <= 1'b0;
      r_raddr  <= '0;
      r_v      <= 1'b0;
      r_d      <= '0;
      r_last   <= 1'b0;
      r_len    <= '0;
      r_n      <= '0;
      r_lcnt   <= '0;
      r_nwords <= '0;
      r_wcnt   <= '0;
      r_sh     <= '0;
      r_shn    <= '0;
      r_pf     <= '0;
      r_pfv    <= 1'b0;
      r_dv     <= 1'b0;
    end else begin
      r_dv <= r_rd;
      r_rd <= 1'b0;

      if (w_take) begin
        r_v    <= 1'b1;
        r_d    <= w_byte;
        r_last <= (r_lcnt == (r_n - (AW+2)'(1)));
        r_lcnt <= r_lcnt + (AW+2)'(1);
      end else if (r_v && bus.i_ready) begin
        r_v    <= 1'b0;
        r_last <= 1'b0;
      end

      if (w_src && w_sh_has) begin
        r_sh  <= {r_sh[23:0], 8'h00};
        r_shn <= r_shn - 3'd1;
        if (r_dv) begin
          r_pf  <= bus.i_rdata;
          r_pfv <= 1'b1;
        end
      end else if (w_src && r_pfv) begin
        r_sh  <= {r_pf[23:0], 8'h00};
        r_shn <= 3'd3;
        r_pf  <= bus.i_rdata;
        r_pfv <= r_dv;
      end else if (w_src) begin
        r_sh  <= {bus.i_rdata[23:0], 8'h00};
        r_shn <= 3'd3;
      end else if (r_dv) begin
        if (r_pfv) begin
          r_sh  <= r_pf;
          r_shn <= 3'd4;
        end
        r_pf  <= bus.i_rdata;
        r_pfv <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.i_cmd && (w_n != '0)) begin
            r_state  <= S_RUN;
            r_busy   <= 1'b1;
            r_len    <= bus.i_len;
            r_n      <= w_n;
            r_lcnt   <= '0;
            r_nwords <= w_nwords;
            r_shn    <= '0;
            r_pfv    <= 1'b0;
            if (w_nwords != '0) begin
              r_rd    <= 1'b1;
              r_raddr <= '0;
              r_wcnt  <= (AW+1)'(1);
            end else begin
              r_wcnt  <= '0;
            end
          end
        end
        S_RUN: begin
          if (r_wcnt == r_nwords) begin
            r_state <= S_DRAIN;
          end else if (w_occ < 3'd2) begin
            r_rd    <= 1'b1;
            r_raddr <= r_wcnt[AW-1:0];
            r_wcnt  <= r_wcnt + (AW+1)'(1);
            if ((r_wcnt + (AW+1)'(1)) == r_nwords) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_fin) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_shn   <= '0;
        r_pfv   <= 1'b0;
      end
    end
  end

  assign bus.o_busy  = r_busy;
  assign bus.o_rd    = r_rd;
  assign bus.o_raddr = r_raddr;
  assign bus.o_v     = r_v;
  assign bus.o_d     = r_d;
  assign bus.o_last  = r_last;
endmodule
`default_nettype wire

// File: tb/tb_txeread.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_txeread : scoreboard bench for txeread (expects TXEREAD_PAD_EN if set)  |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module tb_txeread;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  txeread_if #(.AW(AW)) bus ();

  txeread #(.AW(AW)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  logic [31:0]   mem [0:63];
  logic [8:0]    sb [$];
  logic [AW-1:0] aq [$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            hs = 0;
  int            rdy_mode = 0;
  logic          p_v = 1'b0;
  logic          p_rdy = 1'b0;
  logic          p_last = 1'b0;
  logic [7:0]    p_d = 8'h00;
  logic [7:0]    exp6 [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Buffer memory: one-cycle read latency, garbage when not reading
  always @(posedge clk) bus.i_rdata <= bus.o_rd ? mem[bus.o_raddr[5:0]] : $urandom;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.i_ready = 1'b1;
      1:       bus.i_ready = ~bus.i_ready;
      default: bus.i_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  always @(negedge clk) begin
    if (rst) begin
      p_v <= 1'b0;
    end else begin
      if (p_v && !p_rdy)
        chk("hold", 32'({bus.o_v, bus.o_last, bus.o_d}), 32'({1'b1, p_last, p_d}));
      if (bus.o_rd) begin
        if (aq.size() == 0) chk("unexp_rd", 32'(bus.o_rd), 32'd0);
        else                chk("raddr", 32'(bus.o_raddr), 32'(aq.pop_front()));
      end
      if (bus.o_v && bus.i_ready) begin
        hs <= hs + 1;
        if (sb.size() == 0) chk("unexp_byte", 32'(bus.o_v), 32'd0);
        else                chk("byte", 32'({bus.o_last, bus.o_d}), 32'(sb.pop_front()));
      end
      p_v    <= bus.o_v;
      p_rdy  <= bus.i_ready;
      p_last <= bus.o_last;
      p_d    <= bus.o_d;
    end
  end

  function automatic int eff_len(input int l);
`ifdef TXEREAD_PAD_EN
    return (l < 60) ? 60 : l;
`else
    return l;
`endif
  endfunction

  task automatic push_pkt(input int l);
    int          n;
    logic [31:0] w;
    logic [7:0]  b;
    n = eff_len(l);
    for (int i = 0; i < (l + 3) / 4; i++) aq.push_back(AW'(i));
    for (int i = 0; i < n; i++) begin
      w = mem[i / 4];
      b = (i < l) ? w[31 - 8 * (i % 4) -: 8] : 8'h00;
      sb.push_back({(i == n - 1), b});
    end
  endtask

  task automatic send(input int l, input bit accept);
    @(posedge clk); #1;
    bus.i_cmd = 1'b1;
    bus.i_len = (AW+2)'(l);
    if (accept && eff_len(l) > 0) push_pkt(l);
    @(posedge clk); #1;
    bus.i_cmd = 1'b0;
    bus.i_len = (AW+2)'($urandom);
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while ((sb.size() != 0 || aq.size() != 0 || bus.o_busy) && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    chk(tag, 32'(sb.size() + aq.size()), 32'd0);
    chk({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t1n;
    int hs0;
    bus.i_cmd   = 1'b0;
    bus.i_len   = '0;
    bus.i_ready = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h11223344;
    mem[1] = 32'h5566AABB;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", 32'({bus.o_busy, bus.o_rd, bus.o_v, bus.o_last, bus.o_d, bus.o_raddr}), 32'd0);
    rst = 1'b0;

    // L=6, ready high: cycle-exact timing
    rdy_mode = 0;
    t1n = eff_len(6);
    send(6, 1'b1);
    for (int c = 1; c <= 9; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (c == 1) begin
        chk("c1_busy", 32'(bus.o_busy), 32'd1);
        chk("c1_rd", 32'(bus.o_rd), 32'd1);
        chk("c1_raddr", 32'(bus.o_raddr), 32'd0);
      end
      chk("t1_v", 32'(bus.o_v), 32'(c >= 3 && c <= 8));
      if (c >= 3 && c <= 8) chk("t1_d", 32'(bus.o_d), 32'(exp6[c - 3]));
      chk("t1_last", 32'(bus.o_last), 32'(c == t1n + 2));
      chk("t1_busy", 32'(bus.o_busy), 32'(c <= t1n + 2));
    end
    wait_done("t1_done");

    // L=8 with ready toggling
    rdy_mode = 1;
    send(8, 1'b1);
    wait_done("t2_done");

`ifdef TXEREAD_PAD_EN
    rdy_mode = 2;
    send(10, 1'b1);
    wait_done("pad10_done");
    send(0, 1'b1);
    wait_done("pad0_done");
`else
    rdy_mode = 0;
    send(0, 1'b1);
    for (int c = 0; c < 6; c++) begin
      chk("l0_busy", 32'(bus.o_busy), 32'd0);
      @(posedge clk); #1;
    end
`endif

    // Command while busy is ignored
    rdy_mode = 0;
    send(5, 1'b1);
    bus.i_cmd = 1'b1;
    bus.i_len = (AW+2)'(20);
    chk("busy_at_cmd2", 32'(bus.o_busy), 32'd1);
    @(posedge clk); #1;
    bus.i_cmd = 1'b0;
    wait_done("ign_done");

    // Reset while byte 3 of a 16-byte packet is presented
    rdy_mode = 0;
    hs0 = hs;
    send(16, 1'b1);
    for (int t = 0; t < 50 && (hs - hs0) < 3; t++) begin @(posedge clk); #1; end
    chk("rst_reach", 32'((hs - hs0) >= 3), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_out", 32'({bus.o_busy, bus.o_rd, bus.o_v, bus.o_last, bus.o_d, bus.o_raddr}), 32'd0);
    sb.delete();
    aq.delete();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("rst_quiet", 32'({bus.o_busy, bus.o_v}), 32'd0);
    end
    send(4, 1'b1);
    wait_done("post_rst_done");

    // Random lengths under random backpressure
    rdy_mode = 2;
    for (int k = 0; k < 6; k++) begin
      send($urandom_range(1, 40), 1'b1);
      wait_done("rand_done");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
